// File: rtl/hazard_pkg.sv
// Shared definitions for the xgriscv hazard controller: memory-wait state
// encoding, default register-index width and the per-stage control bundle.
package hazard_pkg;

  localparam int DEF_RFIDX_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ABORT = 2'b10
  } mem_state_e;

  // One bit per pipeline register, fetch side first.
  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_ctrl_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks a multi-cycle data-memory access, raises mem_stall while it is
// outstanding and aborts it (sticky mem_err) after MEM_TIMEOUT cycles.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dmem_reqM,
  input  logic       dmem_readyM,
  output logic       mem_stall,
  output logic       mem_err,
  output mem_state_e state_dbg
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] LAST_CNT = WCW'(MEM_TIMEOUT - 1);

  mem_state_e     state_q, state_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  // Handshake: an access is held in M while dmem_reqM=1; it completes in
  // the cycle where dmem_reqM and dmem_readyM are both high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (dmem_reqM && !dmem_readyM) begin
          state_d = WAIT;
          cnt_d   = WCW'(1);
        end
      end
      WAIT: begin
        if (dmem_readyM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ABORT;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + WCW'(1);
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The abandoned access is let through during ABORT so M can drain.
  assign mem_stall = dmem_reqM && !dmem_readyM && (state_q != ABORT) && !reset;
  assign mem_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage xgriscv pipeline: load-use,
// redirect and memory-wait hazards plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RFIDX_WIDTH-1:0] rs1D,
  input  logic [RFIDX_WIDTH-1:0] rs2D,
  input  logic                   useRs2D,
  input  logic [RFIDX_WIDTH-1:0] rdE,
  input  logic                   memtoregE,
  input  logic                   regwriteE,
  input  logic                   redirectE,
  input  logic                   dmem_reqM,
  input  logic                   dmem_readyM,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   stallM,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushW,
  output logic                   mem_err,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt,
  output mem_state_e             fsm_state
);

  logic        mem_stall;
  logic        load_use;
  logic        redirect_act;
  stage_ctrl_t stall_c, flush_c;
  logic        unused_ctrl_bits;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .dmem_reqM  (dmem_reqM),
    .dmem_readyM(dmem_readyM),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .state_dbg  (fsm_state)
  );

  assign load_use = memtoregE && regwriteE && (rdE != '0) &&
                    ((rdE == rs1D) || (useRs2D && (rdE == rs2D)));

  always_comb begin
    stall_c      = '0;
    flush_c      = '0;
    redirect_act = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        stall_c = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b0};
        flush_c.w = 1'b1;
      end else if (redirectE) begin
        // The squashed ID instruction makes any load-use moot.
        redirect_act = 1'b1;
        flush_c.d    = 1'b1;
        flush_c.e    = 1'b1;
      end else if (load_use) begin
        stall_c.f = 1'b1;
        stall_c.d = 1'b1;
        flush_c.e = 1'b1;
      end
    end
  end

  assign stallF = stall_c.f;
  assign stallD = stall_c.d;
  assign stallE = stall_c.e;
  assign stallM = stall_c.m;
  assign flushD = flush_c.d;
  assign flushE = flush_c.e;
  assign flushW = flush_c.w;
  assign unused_ctrl_bits = ^{stall_c.w, flush_c.f, flush_c.m};

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c.f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_act && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RW   = 5;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int EXPW = 8 + 2 * CW + 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] rs1D = '0, rs2D = '0, rdE = '0;
  logic          useRs2D = 1'b0, memtoregE = 1'b0, regwriteE = 1'b0;
  logic          redirectE = 1'b0, dmem_reqM = 1'b0, dmem_readyM = 1'b0;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    fsm_state;

  logic [EXPW-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: cycles already spent waiting, abort pending, sticky error.
  int            m_waited = 0;
  bit            m_abort = 0;
  bit            m_err = 0;
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_fcnt = '0;

  pipe_hazard_ctrl #(.RFIDX_WIDTH(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .useRs2D(useRs2D), .rdE(rdE),
    .memtoregE(memtoregE), .regwriteE(regwriteE), .redirectE(redirectE),
    .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: one call = one clock cycle of stimulus, expected response queued.
  task automatic cyc(input bit rst_v, input int rs1, input int rs2, input bit use2,
                     input int rd, input bit mtr, input bit rw, input bit redir,
                     input bit req, input bit rdy);
    bit       ms, lu;
    bit [6:0] c;
    bit [1:0] st;
    @(negedge clk);
    reset = rst_v; rs1D = RW'(rs1); rs2D = RW'(rs2); useRs2D = use2; rdE = RW'(rd);
    memtoregE = mtr; regwriteE = rw; redirectE = redir; dmem_reqM = req; dmem_readyM = rdy;
    if (rst_v) begin
      m_waited = 0; m_abort = 0; m_err = 0; m_scnt = '0; m_fcnt = '0;
      exp_q.push_back('0);
      return;
    end
    ms = req && !rdy && !m_abort;
    lu = mtr && rw && (rd != 0) && ((rd == rs1) || (use2 && (rd == rs2)));
    // c = {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    if (ms)         c = 7'b1111_001;
    else if (redir) c = 7'b0000_110;
    else if (lu)    c = 7'b1100_010;
    else            c = 7'b0000_000;
    st = m_abort ? 2'd2 : (m_waited != 0 ? 2'd1 : 2'd0);
    exp_q.push_back({c, m_err, m_scnt, m_fcnt, st});
    if (c[6] && m_scnt != CNT_MAX) m_scnt = m_scnt + 1'b1;
    if (redir && !ms && m_fcnt != CNT_MAX) m_fcnt = m_fcnt + 1'b1;
    if (m_abort) m_abort = 0;
    else if (m_waited == 0) begin
      if (req && !rdy) m_waited = 1;
    end else if (rdy) m_waited = 0;
    else if (m_waited == TO - 1) begin
      m_waited = 0; m_abort = 1; m_err = 1;
    end else m_waited++;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EXPW-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW}), 32'(e[EXPW-1 -: 7]));
      check("mem_err", 32'(mem_err), 32'(e[EXPW-8]));
      check("stall_cnt", 32'(stall_cnt), 32'(e[2*CW+1 -: CW]));
      check("flush_cnt", 32'(flush_cnt), 32'(e[CW+1 -: CW]));
      check("fsm_state", 32'(fsm_state), 32'(e[1:0]));
    end
  end

  initial begin
    // reset state, including a request pending while reset is high
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 5, 0, 0, 5, 1, 1, 0, 0, 0);
    idle();
    // load-use on rs1, one cycle, then EX moves on
    cyc(0, 5, 0, 0, 5, 1, 1, 0, 0, 0);
    idle();
    // load-use squashed by redirect
    cyc(0, 5, 0, 0, 5, 1, 1, 1, 0, 0);
    idle();
    // x0 never hazards
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // rs2 only counts when used
    cyc(0, 1, 5, 0, 5, 1, 1, 0, 0, 0);
    cyc(0, 1, 5, 1, 5, 1, 1, 0, 0, 0);
    // non-load or non-writing producer
    cyc(0, 5, 0, 0, 5, 0, 1, 0, 0, 0);
    cyc(0, 5, 0, 0, 5, 1, 0, 0, 0, 0);
    // single-cycle access: no stall
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // ready three cycles after request
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    // redirect held across a wait only lands after release
    for (int i = 0; i < 3; i++) cyc(0, 5, 0, 0, 5, 1, 1, 1, 1, 0);
    cyc(0, 5, 0, 0, 5, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // back-to-back accesses
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // timeout: request never served, abort cycle lets M through
    for (int i = 0; i < TO + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    // reset mid-wait
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic; counters saturate between periodic resets
    for (int n = 0; n < 800; n++) begin
      cyc((n % 97) == 96,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
          $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage xgriscv pipeline; sits beside the operand-forwarding logic in EX.
- Covers the hazards that forwarding cannot resolve: load-use (stall 1 cycle), taken branch/jump redirect (flush 2 younger stages), and multi-cycle data-memory access (freeze F..M, bubble W).
- Owns the memory-wait FSM with a timeout watchdog and saturating performance counters for stall cycles and flush events.

Parameters:
- RFIDX_WIDTH, 5, register-file index width.
- MEM_TIMEOUT, 64, max cycles in WAIT before abort; must be ≥2.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- rs1D  in  RFIDX_WIDTH  ID-stage source 1 index
- rs2D  in  RFIDX_WIDTH  ID-stage source 2 index
- useRs2D  in  1  ID instruction reads rs2 (0 for I/U/J types)
- rdE  in  RFIDX_WIDTH  EX-stage destination
- memtoregE  in  1  EX instruction is a load
- regwriteE  in  1  EX instruction writes the register file
- redirectE  in  1  taken branch/jump resolved in EX
- dmem_reqM  in  1  MEM stage has a load/store
- dmem_readyM  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold the pipeline register
- flushD, flushE, flushW  out  1 each  insert a bubble into the pipeline register
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  cycles with stallF=1, saturating
- flush_cnt  out  CNT_W  redirect flush events, saturating

Behaviour:
- Reset (asynchronous): FSM=IDLE, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. All stall/flush outputs are combinational and evaluate to 0 while reset=1.
- load_use = memtoregE & regwriteE & rdE≠0 & (rdE==rs1D | (useRs2D & rdE==rs2D)).
- FSM states:
  - IDLE: if dmem_reqM & !dmem_readyM → WAIT, wait counter=1. Otherwise stay in IDLE.
  - WAIT: if dmem_readyM → IDLE. Else if wait counter==MEM_TIMEOUT-1 → ABORT. Else increment the counter.
  - ABORT: set mem_err=1 and go to IDLE unconditionally.
- mem_stall = dmem_reqM & !dmem_readyM & state≠ABORT. This is combinational, so it asserts in the same cycle as the request. In ABORT the access is abandoned: mem_stall=0 and M advances.
- Output priority, highest first:
  1. mem_stall: stallF=stallD=stallE=stallM=1, flushW=1; all other outputs 0. Redirect and load-use are ignored and re-evaluated after release, since EX/ID are frozen.
  2. redirectE: flushD=flushE=1; no stalls. This suppresses load_use because the ID instruction is squashed.
  3. load_use: stallF=stallD=1, flushE=1.
  4. Otherwise all outputs 0.
- flush_cnt increments when priority level 2 is active, i.e. redirectE & !mem_stall.
- stall_cnt increments on every cycle with stallF=1.
- Both counters saturate at all-ones and never wrap.
- Edge cases:
  - dmem_readyM in the same cycle as dmem_reqM: no stall, FSM stays IDLE.
  - Back-to-back accesses: each is judged independently; WAIT→IDLE→WAIT is legal.
  - mem_err is cleared only by reset.
  - Reset asserted mid-WAIT: immediate return to IDLE with no residual stall.
- Latency: all hazard responses are combinational (0 cycles); FSM and counters update on the rising edge of clk.

Decomposition:
- Shared package `hazard_pkg`:
  - state encoding IDLE=2'b00, WAIT=2'b01, ABORT=2'b10
  - RFIDX_WIDTH default
  - stage-control bundle field order: F, D, E, M, W
- One sub-module, `mem_wait_fsm`:
  - Inputs: clk, reset, dmem_reqM, dmem_readyM.
  - Outputs: mem_stall, mem_err.
  - Contains the FSM and the wait counter.
- The top level holds load-use detection, the priority mux and the counters.

Test Plan:
- Load x5 in EX (rdE=5, memtoregE=1, regwriteE=1), rs1D=5 → stallF=stallD=flushE=1 for exactly 1 cycle; stall_cnt=1.
- Same load-use but with redirectE=1 → flushD=flushE=1, stallF=0; flush_cnt=1, stall_cnt unchanged. Also rdE=0 with rs1D=0 → no stall.
- rs2D=5, useRs2D=0, load rdE=5 → no stall. Then useRs2D=1 → stall.
- dmem_reqM=1 with dmem_readyM arriving 3 cycles later → stallF..M=1 and flushW=1 for 3 cycles, FSM IDLE→WAIT→IDLE, stall_cnt=3. Then redirectE held during the wait → flushD/flushE are asserted only after release.
- dmem_reqM=1, dmem_readyM never asserted, MEM_TIMEOUT=4 → stall for 4 cycles, ABORT cycle with stall=0 and mem_err=1 (sticky); an async reset pulse clears all state and counters.
